// File: rtl/mac_rx_pkg.sv
// Shared definitions for the multi-class MAC receive demux:
// SFD byte, descriptor bit positions, FSM states and the byte-wide FCS update.
package mac_rx_pkg;

    localparam logic [7:0] SFD_BYTE = 8'hD5;

    // Descriptor layout: [12:0] length, [13] reserved, [14] len_err, [15] crc_err
    localparam int LEN_MSB = 12;
    localparam int LEN_ERR = 14;
    localparam int CRC_ERR = 15;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        BODY,
        DRAIN,
        COMMIT,
        DROP
    } rx_state_e;

    // 802.3 CRC-32, MSB-first register with data bits taken LSB first.
    // Running it over a frame plus its own FCS leaves 32'hc704dd7b.
    function automatic logic [31:0] crc32_8023(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_rx_sfifo.sv
// Synchronous FIFO with registered read data, full/empty flags and a free count.
// Writes when full and reads when empty are ignored; dout holds on an ignored read.
module mac_rx_sfifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   free
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_wr, do_rd;

    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign full  = (cnt == DEPTH);
    assign empty = (cnt == '0);
    assign free  = DEPTH - cnt;

    // Storage array, no reset needed: contents are only observed behind cnt
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
    end

    // Pointers, occupancy and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            dout <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) begin
                rp   <= rp + 1'b1;
                dout <= mem[rp];
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mac_rx_class_demux.sv
// Byte-wide Ethernet receive front end: strips preamble/SFD, classifies each
// frame by the byte at CLASS_OFFSET, stores admitted frames whole in a per-class
// data FIFO and writes one 16-bit descriptor (length, len_err, crc_err) per frame.
// Optional feature: define MAC_RX_DROP_CNT_EN to build the per-class saturating
// drop counters; otherwise drop_cnt is tied to zero.
module mac_rx_class_demux
    import mac_rx_pkg::*;
#(
    parameter int          NUM_CLASS    = 2,
    parameter int          CLASS_OFFSET = 13,
    parameter int          DATA_AW      = 12,
    parameter int          PTR_AW       = 5,
    parameter int          MAX_BYTES    = 1522,
    parameter int          MIN_BYTES    = 64,
    parameter logic [31:0] CRC_RESULT   = 32'hc704dd7b
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_dv,
    input  logic [7:0]               rx_d,
    input  logic [8*NUM_CLASS-1:0]   class_val,
    input  logic [NUM_CLASS-1:0]     data_fifo_rd,
    output logic [8*NUM_CLASS-1:0]   data_fifo_dout,
    input  logic [NUM_CLASS-1:0]     ptr_fifo_rd,
    output logic [16*NUM_CLASS-1:0]  ptr_fifo_dout,
    output logic [NUM_CLASS-1:0]     ptr_fifo_empty,
    output logic [16*NUM_CLASS-1:0]  drop_cnt
);

    localparam int CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam int D  = CLASS_OFFSET + 1;

    rx_state_e          state;
    logic [4:0]         hdr_idx;
    logic [12:0]        byte_cnt;
    logic [4:0]         flush_cnt;
    logic [CW-1:0]      cls;
    logic               trunc, late_sfd;
    logic [31:0]        crc;
    logic [D-1:0][7:0]  dly;

    logic               dwr_en;
    logic [CW-1:0]      dwr_cls;
    logic [7:0]         dwr_byte;
    logic               pwr_en;
    logic [CW-1:0]      pwr_cls;
    logic [15:0]        pwr_desc;
    logic               drop_inc;
    logic [CW-1:0]      drop_cls;

    logic [CW-1:0]      cls_hit;
    logic               admit, is_sfd, emit, shift;
    logic [15:0]        desc_next;

    logic [NUM_CLASS-1:0][DATA_AW:0] data_free;
    logic [NUM_CLASS-1:0]            ptr_full;
    logic [NUM_CLASS-1:0]            data_full_unused;
    logic [NUM_CLASS-1:0][PTR_AW:0]  ptr_free_unused;
    logic                            unused_slot0;

    assign unused_slot0 = ^class_val[7:0];

    assign is_sfd = rx_dv && (rx_d == SFD_BYTE);
    assign emit   = (state == BODY && rx_dv) || (state == DRAIN);
    assign shift  = (state == HDR && rx_dv) || emit;
    assign admit  = (data_free[cls_hit] >= (DATA_AW+1)'(MAX_BYTES)) && !ptr_full[cls_hit];

    // Class lookup: lowest matching class k>=1 wins, class 0 when nothing matches
    always_comb begin
        cls_hit = '0;
        for (int k = NUM_CLASS - 1; k >= 1; k--)
            if (rx_d == class_val[8*k +: 8]) cls_hit = CW'(k);
    end

    // Descriptor assembled from the stored length, truncation and FCS residue
    always_comb begin
        desc_next            = '0;
        desc_next[LEN_MSB:0] = byte_cnt;
        desc_next[LEN_ERR]   = trunc || (byte_cnt < 13'(MIN_BYTES));
        desc_next[CRC_ERR]   = (crc != CRC_RESULT);
    end

    // Receive FSM plus the delay line, FCS and registered FIFO write ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hdr_idx   <= '0;
            byte_cnt  <= '0;
            flush_cnt <= '0;
            cls       <= '0;
            trunc     <= 1'b0;
            late_sfd  <= 1'b0;
            crc       <= '1;
            dly       <= '0;
            dwr_en    <= 1'b0;
            dwr_cls   <= '0;
            dwr_byte  <= '0;
            pwr_en    <= 1'b0;
            pwr_cls   <= '0;
            pwr_desc  <= '0;
            drop_inc  <= 1'b0;
            drop_cls  <= '0;
        end else begin
            dwr_en   <= 1'b0;
            pwr_en   <= 1'b0;
            drop_inc <= 1'b0;

            if (shift) dly <= {dly[D-2:0], rx_dv ? rx_d : 8'h00};

            // Bytes leave the delay line into the FIFO until MAX_BYTES are stored
            if (emit) begin
                if (byte_cnt < 13'(MAX_BYTES)) begin
                    dwr_en   <= 1'b1;
                    dwr_cls  <= cls;
                    dwr_byte <= dly[D-1];
                    byte_cnt <= byte_cnt + 13'd1;
                    crc      <= crc32_8023(crc, dly[D-1]);
                end else begin
                    trunc <= 1'b1;
                end
            end

            case (state)
                IDLE, PRE: begin
                    hdr_idx  <= '0;
                    byte_cnt <= '0;
                    trunc    <= 1'b0;
                    late_sfd <= 1'b0;
                    crc      <= '1;
                    if (!rx_dv)      state <= IDLE;
                    else if (is_sfd) state <= HDR;
                    else             state <= PRE;
                end
                HDR: begin
                    if (!rx_dv) begin
                        drop_inc <= 1'b1;
                        drop_cls <= '0;
                        state    <= IDLE;
                    end else begin
                        hdr_idx <= hdr_idx + 5'd1;
                        if (hdr_idx == 5'(CLASS_OFFSET)) begin
                            cls <= cls_hit;
                            if (admit) begin
                                state <= BODY;
                            end else begin
                                drop_cls <= cls_hit;
                                state    <= DROP;
                            end
                        end
                    end
                end
                BODY: begin
                    if (!rx_dv) begin
                        flush_cnt <= 5'(D);
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (is_sfd) late_sfd <= 1'b1;
                    flush_cnt <= flush_cnt - 5'd1;
                    if (flush_cnt == 5'd1) state <= COMMIT;
                end
                COMMIT: begin
                    pwr_en   <= 1'b1;
                    pwr_cls  <= cls;
                    pwr_desc <= desc_next;
                    // A new SFD arrived before the flush finished: that frame is lost
                    if (late_sfd || is_sfd) begin
                        drop_cls <= '0;
                        state    <= DROP;
                    end else begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (!rx_dv) begin
                        drop_inc <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-class data and descriptor FIFOs
    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_cls
        mac_rx_sfifo #(.W(8), .AW(DATA_AW)) u_data (
            .clk   (clk),
            .rst   (rst),
            .wr    (dwr_en && (dwr_cls == CW'(k))),
            .din   (dwr_byte),
            .rd    (data_fifo_rd[k]),
            .dout  (data_fifo_dout[8*k +: 8]),
            .full  (data_full_unused[k]),
            .empty (),
            .free  (data_free[k])
        );
        mac_rx_sfifo #(.W(16), .AW(PTR_AW)) u_ptr (
            .clk   (clk),
            .rst   (rst),
            .wr    (pwr_en && (pwr_cls == CW'(k))),
            .din   (pwr_desc),
            .rd    (ptr_fifo_rd[k]),
            .dout  (ptr_fifo_dout[16*k +: 16]),
            .full  (ptr_full[k]),
            .empty (ptr_fifo_empty[k]),
            .free  (ptr_free_unused[k])
        );
    end

`ifdef MAC_RX_DROP_CNT_EN
    logic [NUM_CLASS-1:0][15:0] drop_q;

    // Saturating per-class drop counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_q <= '0;
        else if (drop_inc && drop_q[drop_cls] != 16'hFFFF)
            drop_q[drop_cls] <= drop_q[drop_cls] + 16'd1;
    end

    assign drop_cnt = drop_q;
`else
    logic unused_drop;
    assign unused_drop = ^{drop_inc, drop_cls};
    assign drop_cnt    = '0;
`endif

endmodule
